// File: rtl/ball_motion_if.sv
// ball_motion_if: per-frame control inputs and registered ball outputs of the motion engine.
// Ports: vsync/launch/hold (into the engine), ball_x/ball_y/state/floor_hit/wall_hit (out of it).
// master = the side driving vsync/launch/hold, slave = the motion engine itself.
interface ball_motion_if;
  logic       vsync;
  logic       launch;
  logic       hold;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [1:0] state;
  logic       floor_hit;
  logic       wall_hit;

  modport master (
    output vsync, launch, hold,
    input  ball_x, ball_y, state, floor_hit, wall_hit
  );

  modport slave (
    input  vsync, launch, hold,
    output ball_x, ball_y, state, floor_hit, wall_hit
  );
endinterface

// File: rtl/ball_motion.sv
// ball_motion: gravity-driven ball advanced once per frame on the leading edge of vsync.
// Ports: clk, rst_n (async, active-low), bus (ball_motion_if.slave); outputs update one clk after vsync asserts.
// Optional macro BALL_AUTO_LAUNCH_EN: self-launch from IDLE and relaunch from REST (attract mode).
module ball_motion #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int RADIUS      = 20,
  parameter int X_START     = 320,
  parameter int Y_START     = 60,
  parameter int VX_INIT     = 2,
  parameter int VY_LAUNCH   = 12,
  parameter int GRAVITY     = 1,
  parameter int DAMP        = 2,
  parameter int MAX_VY      = 15,
  parameter int REST_FRAMES = 60,
  parameter bit VSYNC_POL   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  ball_motion_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FLIGHT = 2'b01,
    REST   = 2'b10,
    BAD    = 2'b11
  } state_t;

  // Bounce limits and constants in the 12-bit signed arithmetic domain.
  localparam logic signed [11:0] XL_S   = 12'(RADIUS);
  localparam logic signed [11:0] XR_S   = 12'(H_ACTIVE - 1 - RADIUS);
  localparam logic signed [11:0] YT_S   = 12'(RADIUS);
  localparam logic signed [11:0] YB_S   = 12'(V_ACTIVE - 1 - RADIUS);
  localparam logic signed [11:0] GRAV_S = 12'(GRAVITY);
  localparam logic signed [11:0] DAMP_S = 12'(DAMP);
  localparam logic signed [11:0] MAXV_S = 12'(MAX_VY);
  localparam logic signed [4:0]  VX_I   = 5'(VX_INIT);
  localparam logic signed [5:0]  VY_L   = 6'(-VY_LAUNCH);
  localparam logic [7:0]         REST_LAST = 8'(REST_FRAMES - 1);

  state_t             st;
  logic [9:0]         ball_x, ball_y;
  logic signed [4:0]  vx;
  logic signed [5:0]  vy;
  logic [7:0]         rest_cnt;
  logic               floor_hit, wall_hit;
  logic               sync_prev;

  logic vs_asserted, fev, go;
  assign vs_asserted = (bus.vsync == VSYNC_POL);
  // One frame event per vsync assertion; hold masks it but sync_prev keeps tracking.
  assign fev = vs_asserted && !sync_prev && !bus.hold;

`ifdef BALL_AUTO_LAUNCH_EN
  assign go = 1'b1;
`else
  assign go = bus.launch;
`endif

  logic signed [11:0] nx, vn_raw, vn, ny;
  always_comb begin
    nx     = $signed({2'b00, ball_x}) + {{7{vx[4]}}, vx};
    vn_raw = {{6{vy[5]}}, vy} + GRAV_S;
    vn     = (vn_raw > MAXV_S) ? MAXV_S : vn_raw;
    ny     = $signed({2'b00, ball_y}) + vn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      ball_x    <= 10'(X_START);
      ball_y    <= 10'(Y_START);
      vx        <= VX_I;
      vy        <= '0;
      rest_cnt  <= '0;
      floor_hit <= 1'b0;
      wall_hit  <= 1'b0;
      sync_prev <= 1'b1;  // an already-asserted vsync at release is not a frame
    end else begin
      sync_prev <= vs_asserted;
      floor_hit <= 1'b0;
      wall_hit  <= 1'b0;
      case (st)
        IDLE: begin
          ball_x <= 10'(X_START);
          ball_y <= 10'(Y_START);
          if (fev && go) begin
            vx <= VX_I;
            vy <= VY_L;
            st <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (fev) begin
            // x axis: walls only count when moving toward them
            if (vx > 5'sd0 && nx >= XR_S) begin
              ball_x   <= 10'(XR_S);
              vx       <= -vx;
              wall_hit <= 1'b1;
            end else if (vx < 5'sd0 && nx <= XL_S) begin
              ball_x   <= 10'(XL_S);
              vx       <= -vx;
              wall_hit <= 1'b1;
            end else begin
              ball_x <= 10'(nx);
            end
            // y axis: floor bounce loses DAMP; too slow to bounce means rest
            if (ny >= YB_S) begin
              ball_y    <= 10'(YB_S);
              floor_hit <= 1'b1;
              if (vn <= DAMP_S) begin
                vy       <= '0;
                rest_cnt <= '0;
                st       <= REST;
              end else begin
                vy <= 6'(DAMP_S - vn);
              end
            end else if (ny <= YT_S) begin
              ball_y <= 10'(YT_S);
              vy     <= '0;
            end else begin
              ball_y <= 10'(ny);
              vy     <= 6'(vn);
            end
          end
        end
        REST: begin
          if (fev) begin
            if (rest_cnt == REST_LAST) begin
`ifdef BALL_AUTO_LAUNCH_EN
              vy       <= VY_L;
              rest_cnt <= '0;
              st       <= FLIGHT;
`else
              ball_x <= 10'(X_START);
              ball_y <= 10'(Y_START);
              st     <= IDLE;
`endif
            end else begin
              rest_cnt <= rest_cnt + 8'd1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.ball_x    = ball_x;
  assign bus.ball_y    = ball_y;
  assign bus.state     = st;
  assign bus.floor_hit = floor_hit;
  assign bus.wall_hit  = wall_hit;

endmodule
